// File: rtl/reg_access_master.sv
`default_nettype none
// =============================================================================
// Module   : reg_access_master
// Purpose  : Initiator for the register select/read/write bus. Takes one
//            command at a time, pulses a one-hot select, captures the
//            read-out and returns it on a valid/ready response port.
//            Define REG_ACC_MST_WR_CHECK_EN to add a read-back check after
//            every in-range write.
// Revision : 1.0 - initial release
// =============================================================================
module reg_access_master #(
    parameter int REG_WIDTH  = 32,
    parameter int REG_NUM    = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_wr,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [REG_WIDTH-1:0]         cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [REG_WIDTH-1:0]         rsp_rdata,
    output logic                         rsp_err,
    output logic [REG_NUM-1:0]           reg_wr_sel,
    output logic                         reg_wr_rd,
    output logic [REG_WIDTH-1:0]         reg_wr_data,
    input  logic [REG_NUM*REG_WIDTH-1:0] reg_rd_out,
    output logic [15:0]                  acc_cnt
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ACCESS  = 3'd1;
    localparam logic [2:0] c_CAPTURE = 3'd2;
    localparam logic [2:0] c_RESP    = 3'd3;
`ifdef REG_ACC_MST_WR_CHECK_EN
    localparam logic [2:0] c_CHK_RD  = 3'd4;
    localparam logic [2:0] c_CHK_CAP = 3'd5;
`endif

    logic [2:0]            state_q,     state_d;
    logic                  wr_q,        wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
`ifdef REG_ACC_MST_WR_CHECK_EN
    logic [REG_WIDTH-1:0]  wdata_q,     wdata_d;
`endif
    logic [REG_NUM-1:0]    sel_q,       sel_d;
    logic                  wr_rd_q,     wr_rd_d;
    logic [REG_WIDTH-1:0]  wr_data_q,   wr_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [REG_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [15:0]           acc_cnt_q,   acc_cnt_d;

    logic                  w_cmd_oor;
    logic [REG_WIDTH-1:0]  w_rd_word;

    function automatic logic [REG_NUM-1:0] f_onehot(input logic [ADDR_WIDTH-1:0] a);
        logic [REG_NUM-1:0] s;
        s = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (a == ADDR_WIDTH'(i)) s[i] = 1'b1;
        end
        return s;
    endfunction

    assign w_cmd_oor = (32'(cmd_addr) >= 32'(REG_NUM));

    // Loop mux keeps out-of-range addresses from ever indexing past the bus.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (addr_q == ADDR_WIDTH'(i)) w_rd_word = reg_rd_out[i*REG_WIDTH +: REG_WIDTH];
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
`ifdef REG_ACC_MST_WR_CHECK_EN
        wdata_d     = wdata_q;
`endif
        sel_d       = '0;
        wr_rd_d     = 1'b0;
        wr_data_d   = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        acc_cnt_d   = acc_cnt_q;
        case (state_q)
            c_IDLE: begin
                if (cmd_valid) begin
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
`ifdef REG_ACC_MST_WR_CHECK_EN
                    wdata_d = cmd_wdata;
`endif
                    if (w_cmd_oor) begin
                        state_d     = c_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = c_ACCESS;
                        sel_d     = f_onehot(cmd_addr);
                        wr_rd_d   = cmd_wr;
                        wr_data_d = cmd_wdata;
                    end
                end
            end
            c_ACCESS: begin
                state_d = c_CAPTURE;
            end
            c_CAPTURE: begin
                if (!wr_q) begin
                    rsp_rdata_d = w_rd_word;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = c_RESP;
                end else begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
`ifdef REG_ACC_MST_WR_CHECK_EN
                    state_d     = c_CHK_RD;
                    sel_d       = f_onehot(addr_q);
`else
                    rsp_valid_d = 1'b1;
                    state_d     = c_RESP;
`endif
                end
            end
`ifdef REG_ACC_MST_WR_CHECK_EN
            c_CHK_RD: begin
                state_d = c_CHK_CAP;
            end
            c_CHK_CAP: begin
                rsp_rdata_d = w_rd_word;
                rsp_err_d   = (w_rd_word != wdata_q);
                rsp_valid_d = 1'b1;
                state_d     = c_RESP;
            end
`endif
            c_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    acc_cnt_d   = acc_cnt_q + 16'd1;
                    state_d     = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
`ifdef REG_ACC_MST_WR_CHECK_EN
            wdata_q     <= '0;
`endif
            sel_q       <= '0;
            wr_rd_q     <= 1'b0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
`ifdef REG_ACC_MST_WR_CHECK_EN
            wdata_q     <= wdata_d;
`endif
            sel_q       <= sel_d;
            wr_rd_q     <= wr_rd_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign cmd_ready   = (state_q == c_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign reg_wr_sel  = sel_q;
    assign reg_wr_rd   = wr_rd_q;
    assign reg_wr_data = wr_data_q;
    assign acc_cnt     = acc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_master.sv
`default_nettype none
// =============================================================================
// Module   : tb_reg_access_master
// Purpose  : Directed bench: 8-register instance with a modelled bank
//            (register 0 is a 1-bit flag) and a 6-register instance for
//            out-of-range addressing.
// Revision : 1.0 - initial release
// =============================================================================
module tb_reg_access_master;

`ifdef REG_ACC_MST_WR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         bank_rst_n;
    logic         cmd_valid, cmd_wr, rsp_ready;
    logic [2:0]   cmd_addr;
    logic [31:0]  cmd_wdata;
    logic         cmd_ready, rsp_valid, rsp_err, wr_rd;
    logic [31:0]  rsp_rdata, wr_data;
    logic [7:0]   sel;
    logic [255:0] rd_out;
    logic [15:0]  acc_cnt;

    logic         b_cmd_valid, b_cmd_wr;
    logic [2:0]   b_cmd_addr;
    logic [31:0]  b_cmd_wdata;
    logic         b_cmd_ready, b_rsp_valid, b_rsp_err, b_wr_rd;
    logic [31:0]  b_rsp_rdata, b_wr_data;
    logic [5:0]   b_sel;
    logic [191:0] b_rd_out;
    logic [15:0]  b_acc_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int exp_cnt;

    reg_access_master #(.REG_WIDTH(32), .REG_NUM(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .reg_wr_sel(sel), .reg_wr_rd(wr_rd),
        .reg_wr_data(wr_data), .reg_rd_out(rd_out), .acc_cnt(acc_cnt)
    );

    reg_access_master #(.REG_WIDTH(32), .REG_NUM(6), .ADDR_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_wr(b_cmd_wr), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .reg_wr_sel(b_sel), .reg_wr_rd(b_wr_rd),
        .reg_wr_data(b_wr_data), .reg_rd_out(b_rd_out), .acc_cnt(b_acc_cnt)
    );

    // Responder bank: register 0 keeps only bit 0, the rest are full width.
    logic [31:0] bank [8];
    always_ff @(posedge clk or negedge bank_rst_n) begin
        if (!bank_rst_n) begin
            for (int i = 0; i < 8; i++) bank[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sel[i] && wr_rd) bank[i] <= (i == 0) ? {31'b0, wr_data[0]} : wr_data;
            end
        end
    end

    always_comb begin
        rd_out = '0;
        for (int i = 0; i < 8; i++) rd_out[i*32 +: 32] = bank[i];
    end

    always_comb begin
        b_rd_out = '0;
        for (int i = 0; i < 6; i++) b_rd_out[i*32 +: 32] = 32'h1000_0000 | i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command from an idle negedge, follow it to its response and
    // leave the bench at the negedge after the response handshake.
    task automatic xact(input logic wr, input logic [2:0] addr, input logic [31:0] wd,
                        output int lat, output int nsel, output logic [7:0] selseen,
                        output logic frd, output logic [31:0] fdata,
                        output logic [31:0] rd, output logic er);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; nsel = 0; selseen = '0; frd = 1'b0; fdata = '0;
        while (!rsp_valid && lat < 20) begin
            if (sel != 8'h00) begin
                if (nsel == 0) begin
                    frd   = wr_rd;
                    fdata = wr_data;
                end
                nsel++;
                selseen = selseen | sel;
            end
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
    endtask

    int          lat, nsel, k;
    logic [7:0]  selseen;
    logic        frd, er;
    logic [31:0] fdata, rd;

    initial begin
        rst_n = 1'b0; bank_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        b_cmd_valid = 1'b0; b_cmd_wr = 1'b0; b_cmd_addr = '0; b_cmd_wdata = '0;
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; bank_rst_n = 1'b1;
        @(negedge clk);

        chk("reset_a", {cmd_ready, rsp_valid, rsp_err, wr_rd, sel, acc_cnt}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000});
        chk("reset_a_data", {rsp_rdata, wr_data}, 64'h0);
        chk("reset_b", {b_cmd_ready, b_rsp_valid, b_rsp_err, b_wr_rd, b_sel, b_wr_data}, {1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0});

        // Read of the flag register straight after reset.
        xact(1'b0, 3'd0, 32'h0, lat, nsel, selseen, frd, fdata, rd, er);
        exp_cnt++;
        chk("rd0_lat", lat, 3);
        chk("rd0_sel", {nsel[7:0], selseen, 7'b0, frd}, {8'd1, 8'h01, 8'h00});
        chk("rd0_rsp", {rd, 31'b0, er}, {32'h0, 32'h0});
        chk("rd0_cnt", {cmd_ready, acc_cnt}, {1'b1, 16'(exp_cnt)});

        xact(1'b1, 3'd0, 32'h0000_0001, lat, nsel, selseen, frd, fdata, rd, er);
        exp_cnt++;
        chk("wr1_lat", lat, CHK ? 5 : 3);
        chk("wr1_sel", {nsel[7:0], selseen, 7'b0, frd}, {CHK ? 8'd2 : 8'd1, 8'h01, 8'h01});
        chk("wr1_wdata", fdata, 32'h1);
        chk("wr1_rsp", {rd, 31'b0, er}, {CHK ? 32'h1 : 32'h0, 32'h0});

        xact(1'b0, 3'd0, 32'h0, lat, nsel, selseen, frd, fdata, rd, er);
        exp_cnt++;
        chk("rd1_rsp", {rd, 31'b0, er}, {32'h1, 32'h0});

        // Flag register keeps only bit 0, so a full-width write mis-reads.
        xact(1'b1, 3'd0, 32'hFFFF_FFFF, lat, nsel, selseen, frd, fdata, rd, er);
        exp_cnt++;
        chk("wrF_wdata", fdata, 32'hFFFF_FFFF);
        chk("wrF_rsp", {rd, 31'b0, er}, {CHK ? 32'h1 : 32'h0, 31'b0, CHK});

        xact(1'b1, 3'd5, 32'hA5A5_5A5A, lat, nsel, selseen, frd, fdata, rd, er);
        exp_cnt++;
        chk("wr5_sel", selseen, 8'h20);
        chk("wr5_rsp", {rd, 31'b0, er}, {CHK ? 32'hA5A5_5A5A : 32'h0, 32'h0});

        xact(1'b0, 3'd5, 32'h0, lat, nsel, selseen, frd, fdata, rd, er);
        exp_cnt++;
        chk("rd5_sel", {nsel[7:0], selseen}, {8'd1, 8'h20});
        chk("rd5_rsp", {rd, 31'b0, er}, {32'hA5A5_5A5A, 32'h0});
        chk("rd5_cnt", acc_cnt, 16'(exp_cnt));

        // Out-of-range command on the 6-register instance.
        b_cmd_valid = 1'b1; b_cmd_addr = 3'd7;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        chk("oor_c1", {b_rsp_valid, b_rsp_err, b_cmd_ready, b_sel}, {1'b1, 1'b1, 1'b0, 6'h00});
        chk("oor_rdata", b_rsp_rdata, 32'h0);
        @(negedge clk);
        chk("oor_done", {b_rsp_valid, b_cmd_ready, b_sel, b_acc_cnt}, {1'b0, 1'b1, 6'h00, 16'd1});

        b_cmd_valid = 1'b1; b_cmd_addr = 3'd5;
        @(negedge clk);
        b_cmd_valid = 1'b0;
        chk("b_rd5_sel", b_sel, 6'h20);
        repeat (2) @(negedge clk);
        chk("b_rd5_rsp", {b_rsp_valid, b_rsp_err, b_rsp_rdata}, {1'b1, 1'b0, 32'h1000_0005});
        @(negedge clk);
        chk("b_rd5_cnt", b_acc_cnt, 16'd2);

        // Backpressure with a command held pending.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 3'd5;
        repeat (3) @(negedge clk);
        chk("bp_first", {rsp_valid, rsp_rdata}, {1'b1, 32'hA5A5_5A5A});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_err, cmd_ready, sel, rsp_rdata, acc_cnt},
                {1'b1, 1'b0, 1'b0, 8'h00, 32'hA5A5_5A5A, 16'(exp_cnt)});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        chk("bp_release", {rsp_valid, cmd_ready, acc_cnt}, {1'b0, 1'b1, 16'(exp_cnt)});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_sel", sel, 8'h20);
        k = 0;
        while (!rsp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("bp_second_lat", k, 2);
        @(negedge clk);
        exp_cnt++;
        chk("bp_second_cnt", acc_cnt, 16'(exp_cnt));

        // Reset pulse while the write select is on the bus.
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 3'd3; cmd_wdata = 32'h0000_1234;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_access_sel", sel, 8'h08);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rst_mid", {cmd_ready, rsp_valid, rsp_err, wr_rd, sel, acc_cnt}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000});
        chk("rst_mid_data", {rsp_rdata, wr_data}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 3'd3, 32'h0, lat, nsel, selseen, frd, fdata, rd, er);
        exp_cnt++;
        chk("rst_after_lat", lat, 3);
        chk("rst_after_rsp", {rd, 31'b0, er}, {32'h0, 32'h0});
        chk("rst_after_cnt", acc_cnt, 16'(exp_cnt));

        // Counter wrap from 16'hFFFF.
        force dut.acc_cnt_q = 16'hFFFF;
        #1;
        release dut.acc_cnt_q;
        @(negedge clk);
        xact(1'b0, 3'd0, 32'h0, lat, nsel, selseen, frd, fdata, rd, er);
        chk("wrap_rsp", rd, 32'h1);
        chk("wrap_cnt", acc_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_access_master.md
# reg_access_master

Initiator side of the register select/read/write interface. Accepts single register commands on a valid/ready port, decodes the address to a one-hot register select, and drives `reg_wr_sel`/`reg_wr_rd`/`reg_wr_data` into a bank of `reg_register_*` responders. It captures the addressed register's read-out and returns it on a valid/ready response port. It sits between the test/host command source and the register bank.

## Interface
- `REG_WIDTH`, 32: register data width.
- `REG_NUM`, 8: number of attached registers; legal range 2..2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 3: command address width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  master can accept a command.
- `cmd_wr`  in  1  1: write, 0: read.
- `cmd_addr`  in  `ADDR_WIDTH`  register index.
- `cmd_wdata`  in  `REG_WIDTH`  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_rdata`  out  `REG_WIDTH`  read data. Reads return the register value. Writes return 0, or the read-back value when the check is compiled in.
- `rsp_err`  out  1  address out of range, or read-back mismatch.
- `reg_wr_sel`  out  `REG_NUM`  one-hot register select.
- `reg_wr_rd`  out  1  1: write, 0: read.
- `reg_wr_data`  out  `REG_WIDTH`  write data to responders.
- `reg_rd_out`  in  `REG_NUM`*`REG_WIDTH`  flattened read-outs; register i is at [i*`REG_WIDTH` +: `REG_WIDTH`].
- `acc_cnt`  out  16  count of completed responses.

## Operation
- States:
  - IDLE, ACCESS, CAPTURE, RESP.
  - CHK_RD and CHK_CAP are added only when the check is compiled in.
- `cmd_ready` = (state == IDLE). A command is accepted on `cmd_valid && cmd_ready`, and `cmd_wr`, `cmd_addr` and `cmd_wdata` are latched at that point.
- IDLE, command accepted:
  - `cmd_addr` >= `REG_NUM`: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No select is driven.
  - Otherwise: go to ACCESS.
- ACCESS:
  - `reg_wr_sel` has exactly the addressed bit set for this one cycle.
  - `reg_wr_rd` = latched wr; `reg_wr_data` = latched wdata.
  - Next state is CAPTURE.
- CAPTURE:
  - `reg_wr_sel` = 0.
  - Read: register `reg_rd_out[addr]` into `rsp_rdata`, then go to RESP.
  - Write: set `rsp_rdata`=0, then go to RESP (or to CHK_RD with the check enabled).
- RESP:
  - `rsp_valid`=1, with `rsp_rdata` and `rsp_err` held stable until `rsp_ready`.
  - On handshake: `acc_cnt` += 1 (wraps 16'hFFFF -> 0), clear `rsp_valid`/`rsp_err`, return to IDLE.
- `reg_wr_sel`, `reg_wr_rd`, `reg_wr_data` and all `rsp_*` signals are registered outputs.
- `reg_wr_rd` and `reg_wr_data` are don't-care while `reg_wr_sel`=0, but are driven to 0 so waveforms stay clean.
- `reg_wr_sel` is never multi-hot and is never asserted outside ACCESS/CHK_RD.
- Reset asserted mid-access: immediately returns to IDLE with all outputs at reset values. The in-flight command is dropped.

## Timing
- Reset values:
  - `cmd_ready`=1 (IDLE).
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `reg_wr_sel`=0, `reg_wr_rd`=0, `reg_wr_data`=0.
  - `acc_cnt`=0.
- Latency, with the handshake at cycle 0:
  - Select asserted in cycle 1.
  - Read data sampled at the end of cycle 2 (read-out valid the cycle after select).
  - `rsp_valid` high from cycle 3.
  - Out-of-range command: `rsp_valid` from cycle 1.
- With `rsp_ready` held high, throughput is one command per 4 cycles.
- `cmd_ready` drops in the cycle after acceptance and returns the cycle after the response handshake.

## Configuration
- `REG_ACC_MST_WR_CHECK_EN` defined: after every in-range write, CAPTURE goes to CHK_RD.
  - CHK_RD drives a read (`reg_wr_rd`=0) with the same one-hot select for one cycle.
  - CHK_CAP samples the read-back into `rsp_rdata` and sets `rsp_err` = (read-back != written data, full width).
  - The write `rsp_valid` then rises in cycle 5 instead of cycle 3.
- `REG_ACC_MST_WR_CHECK_EN` undefined: CHK_RD and CHK_CAP do not exist, and writes always respond with `rsp_rdata`=0, `rsp_err`=0.

## Test plan
- Reset, then read addr 0 of a single-bit RW flag register -> `reg_wr_sel`=8'h01 for one cycle with `reg_wr_rd`=0; `rsp_rdata`=0, `rsp_err`=0, `rsp_valid` in cycle 3, `acc_cnt`=1.
- Write 32'h0000_0001 to addr 0, then read addr 0 -> read returns 32'h1. With the check enabled, the write responds with `rsp_rdata`=32'h1 and `rsp_err`=0.
- Check enabled, write 32'hFFFF_FFFF to the flag register -> read-back 32'h1 and `rsp_err`=1. With the check disabled -> `rsp_err`=0.
- Read addr 7 with `REG_NUM`=6 -> no select pulse, `rsp_valid` in cycle 1, `rsp_err`=1, `rsp_rdata`=0.
- Hold `rsp_ready`=0 for 10 cycles with `cmd_valid` held high -> `rsp_*` stable, `cmd_ready`=0, no second select until the handshake.
- Pulse `rst_n` low during ACCESS, and separately preload `acc_cnt` to 16'hFFFF then complete one access:
  - Reset pulse -> all outputs at reset values, next command completes normally.
  - Completed access at 16'hFFFF -> `acc_cnt`=0.
